rename_reg_file: RTL and testbench

Parametrised architectural register file with rename status for the Tomasulo core, issuing up to ISSUE_W instructions per cycle. Each cycle it resolves every issuing instruction's source operands to either a value (V) or a producing ROB tag (Q). It records new destination renames and retires committed results. It also clears all rename state on a branch flush. It sits between decode/dispatch (lookup and rename) and the ROB commit stage (writeback), and generalises the single-issue register status block to N-wide issue with intra-group dependency and commit bypass.

---
 rtl/rename_reg_file.sv | 109 ++++++++++
 tb/tb_rename_reg_file.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// rename_reg_file: N-wide register status/value file resolving sources to value or ROB tag,
// with intra-group forwarding and commit bypass.
module rename_reg_file #(
    parameter int NREG    = 32,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int ISSUE_W = 2,
    parameter int RW      = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [ISSUE_W-1:0]       iss_valid,
    input  logic [ISSUE_W-1:0]       iss_rs1_hv,
    input  logic [ISSUE_W-1:0]       iss_rs2_hv,
    input  logic [ISSUE_W-1:0]       iss_rd_hv,
    input  logic [ISSUE_W*RW-1:0]    iss_rs1,
    input  logic [ISSUE_W*RW-1:0]    iss_rs2,
    input  logic [ISSUE_W*RW-1:0]    iss_rd,
    input  logic [ISSUE_W*TAG_W-1:0] iss_tag,
    output logic [ISSUE_W*XLEN-1:0]  vj,
    output logic [ISSUE_W*XLEN-1:0]  vk,
    output logic [ISSUE_W*TAG_W-1:0] qj,
    output logic [ISSUE_W*TAG_W-1:0] qk,
    input  logic                     cm_valid,
    input  logic [RW-1:0]            cm_rd,
    input  logic [TAG_W-1:0]         cm_tag,
    input  logic [XLEN-1:0]          cm_data,
    input  logic                     flush
);
    logic [NREG-1:0]  busy;
    logic [TAG_W-1:0] tag_r  [NREG];
    logic [XLEN-1:0]  data_r [NREG];

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
        for (genvar k = 0; k < 2; k++) begin : g_src
            logic [RW-1:0]    s;
            logic             hv;
            logic             fwd;
            logic [TAG_W-1:0] ftag;
            logic [XLEN-1:0]  v;
            logic [TAG_W-1:0] q;
            assign s  = (k == 0) ? iss_rs1[i*RW +: RW] : iss_rs2[i*RW +: RW];
            assign hv = (k == 0) ? iss_rs1_hv[i] : iss_rs2_hv[i];
            // later (younger) older-slot matches overwrite earlier ones
            always_comb begin
                fwd  = 1'b0;
                ftag = '0;
                for (int j = 0; j < i; j++)
                    if (iss_valid[j] && iss_rd_hv[j] && iss_rd[j*RW +: RW] == s) begin
                        fwd  = 1'b1;
                        ftag = iss_tag[j*TAG_W +: TAG_W];
                    end
            end
            always_comb begin
                v = '0;
                q = '0;
                if (!iss_valid[i] || !hv || s == '0) begin
                    v = '0;
                end else if (fwd) begin
                    q = ftag;
                end else if (busy[s] && cm_valid && cm_tag == tag_r[s]) begin
                    v = cm_data;
                end else if (busy[s]) begin
                    q = tag_r[s];
                end else begin
                    v = data_r[s];
                end
            end
            if (k == 0) begin : g_j
                assign vj[i*XLEN +: XLEN]   = v;
                assign qj[i*TAG_W +: TAG_W] = q;
            end else begin : g_k
                assign vk[i*XLEN +: XLEN]   = v;
                assign qk[i*TAG_W +: TAG_W] = q;
            end
        end
    end

    // statement order sets priority: commit clear, then flush, then issue (youngest slot last)
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                tag_r[r]  <= '0;
                data_r[r] <= '0;
            end
        end else if (rdy) begin
            if (cm_valid && cm_rd != '0) begin
                data_r[cm_rd] <= cm_data;
                if (busy[cm_rd] && tag_r[cm_rd] == cm_tag) begin
                    busy[cm_rd]  <= 1'b0;
                    tag_r[cm_rd] <= '0;
                end
            end
            if (flush) begin
                busy <= '0;
                for (int r = 0; r < NREG; r++)
                    tag_r[r] <= '0;
            end else begin
                for (int i = 0; i < ISSUE_W; i++)
                    if (iss_valid[i] && iss_rd_hv[i] && iss_rd[i*RW +: RW] != '0) begin
                        busy[iss_rd[i*RW +: RW]]  <= 1'b1;
                        tag_r[iss_rd[i*RW +: RW]] <= iss_tag[i*TAG_W +: TAG_W];
                    end
            end
        end
    end
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_rename_reg_file;
    localparam int W = 2;

    typedef struct packed {
        logic [31:0] vj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic [3:0]  qk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, rdy, cm_valid, flush;
    logic [W-1:0]  iss_valid, iss_rs1_hv, iss_rs2_hv, iss_rd_hv;
    logic [W*5-1:0] iss_rs1, iss_rs2, iss_rd;
    logic [W*4-1:0] iss_tag, qj, qk;
    logic [W*32-1:0] vj, vk;
    logic [4:0]    cm_rd;
    logic [3:0]    cm_tag;
    logic [31:0]   cm_data;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    rename_reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_rs1_hv(iss_rs1_hv), .iss_rs2_hv(iss_rs2_hv), .iss_rd_hv(iss_rd_hv),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .vj(vj), .vk(vk), .qj(qj), .qk(qk),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(string name, int slot, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s slot%0d @%0t: got %h expected %h", name, slot, $time, act, exp);
        end
    endtask

    // monitor: an issuing slot consumes one expectation, idle slots must read all-zero
    always @(negedge clk) begin
        for (int i = 0; i < W; i++) begin
            exp_t e;
            e = '0;
            if (iss_valid[i]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard slot%0d @%0t: got output with no expectation", i, $time);
                end else e = sb.pop_front();
            end
            cmp("vj", i, vj[i*32 +: 32], e.vj);
            cmp("qj", i, {28'd0, qj[i*4 +: 4]}, {28'd0, e.qj});
            cmp("vk", i, vk[i*32 +: 32], e.vk);
            cmp("qk", i, {28'd0, qk[i*4 +: 4]}, {28'd0, e.qk});
        end
    end

    task automatic clr();
        iss_valid = '0; iss_rs1_hv = '0; iss_rs2_hv = '0; iss_rd_hv = '0;
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_tag = '0;
        cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0; flush = 1'b0;
    endtask

    task automatic src(int i, logic h1, logic [4:0] r1, logic h2, logic [4:0] r2);
        iss_valid[i] = 1'b1;
        iss_rs1_hv[i] = h1; iss_rs1[i*5 +: 5] = r1;
        iss_rs2_hv[i] = h2; iss_rs2[i*5 +: 5] = r2;
    endtask

    task automatic dst(int i, logic [4:0] rd, logic [3:0] t);
        iss_valid[i] = 1'b1;
        iss_rd_hv[i] = 1'b1; iss_rd[i*5 +: 5] = rd; iss_tag[i*4 +: 4] = t;
    endtask

    task automatic cm(logic [4:0] rd, logic [3:0] t, logic [31:0] d);
        cm_valid = 1'b1; cm_rd = rd; cm_tag = t; cm_data = d;
    endtask

    task automatic expect_out(logic [31:0] ej, logic [3:0] eqj, logic [31:0] ek, logic [3:0] eqk);
        sb.push_back('{vj: ej, qj: eqj, vk: ek, qk: eqk});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        rst = 1'b1; rdy = 1'b1;
        step(); step();
        rst = 1'b0;
        src(0, 1, 5'd5, 1, 5'd0); dst(0, 5'd0, 4'd1); expect_out(0, 0, 0, 0);
        step();
        cm(5'd3, 4'd1, 32'hDEADBEEF);
        step();
        src(0, 1, 5'd3, 0, 5'd0); expect_out(32'hDEADBEEF, 0, 0, 0);
        step();
        dst(0, 5'd7, 4'd2); expect_out(0, 0, 0, 0);
        src(1, 1, 5'd7, 1, 5'd3); expect_out(0, 4'd2, 32'hDEADBEEF, 0);
        step();
        src(0, 0, 5'd0, 1, 5'd7); expect_out(0, 0, 0, 4'd2);
        step();
        cm(5'd7, 4'd2, 32'h55);
        src(1, 1, 5'd7, 0, 5'd0); expect_out(32'h55, 0, 0, 0);
        step();
        src(0, 1, 5'd7, 0, 5'd0); expect_out(32'h55, 0, 0, 0);
        step();
        dst(0, 5'd4, 4'd3); expect_out(0, 0, 0, 0);
        step();
        cm(5'd4, 4'd3, 32'h44);
        src(0, 1, 5'd4, 0, 5'd0); dst(0, 5'd4, 4'd6); expect_out(32'h44, 0, 0, 0);
        step();
        src(0, 1, 5'd4, 0, 5'd0); dst(0, 5'd9, 4'd5); expect_out(0, 4'd6, 0, 0);
        src(1, 0, 5'd0, 1, 5'd4); dst(1, 5'd9, 4'd7); expect_out(0, 0, 0, 4'd6);
        step();
        src(0, 1, 5'd9, 0, 5'd0); expect_out(0, 4'd7, 0, 0);
        src(1, 1, 5'd9, 1, 5'd4); expect_out(0, 4'd7, 0, 4'd6);
        step();
        cm(5'd4, 4'd2, 32'h99);
        step();
        src(0, 1, 5'd4, 0, 5'd0); expect_out(0, 4'd6, 0, 0);
        step();
        dst(0, 5'd1, 4'd8); expect_out(0, 0, 0, 0);
        dst(1, 5'd2, 4'd9); expect_out(0, 0, 0, 0);
        step();
        flush = 1'b1; cm(5'd1, 4'd3, 32'h11);
        src(0, 1, 5'd1, 0, 5'd0); dst(0, 5'd5, 4'd10); expect_out(0, 4'd8, 0, 0);
        step();
        src(0, 1, 5'd1, 1, 5'd2); expect_out(32'h11, 0, 0, 0);
        src(1, 1, 5'd5, 1, 5'd4); expect_out(0, 0, 32'h99, 0);
        step();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            src(0, 1, 5'd3, 0, 5'd0); dst(0, 5'd3, 4'd11); cm(5'd3, 4'd1, 32'h12345678);
            expect_out(32'hDEADBEEF, 0, 0, 0);
            step();
        end
        rdy = 1'b1;
        src(0, 1, 5'd3, 0, 5'd0); expect_out(32'hDEADBEEF, 0, 0, 0);
        src(1, 0, 5'd0, 1, 5'd7); expect_out(0, 0, 32'h55, 0);
        step();
        dst(1, 5'd6, 4'd12); expect_out(0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        src(0, 1, 5'd3, 0, 5'd0); expect_out(0, 0, 0, 0);
        src(1, 1, 5'd6, 1, 5'd7); expect_out(0, 0, 0, 0);
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
